// File: rtl/modop_arbiter_if.sv
// modop_arbiter_if: requester handshakes, modulus-update handshake, shared-unit
// issue/result lines and response bus of the modop arbiter, bundled as one port.
interface modop_arbiter_if #(
  parameter int NREQ = 4,
  parameter int LOGQ = 64
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_op;
  logic [NREQ*LOGQ-1:0] req_A;
  logic [NREQ*LOGQ-1:0] req_B;
  logic                 q_load;
  logic [LOGQ-1:0]      q_in;
  logic                 q_ack;
  logic                 u_valid;
  logic                 u_op;
  logic [LOGQ-1:0]      u_A;
  logic [LOGQ-1:0]      u_B;
  logic [LOGQ-1:0]      u_q;
  logic [LOGQ-1:0]      u_C;
  logic [NREQ-1:0]      rsp_valid;
  logic [LOGQ-1:0]      rsp_C;
  logic                 busy;

  // Arbiter side.
  modport slave (
    input  req_valid, req_op, req_A, req_B, q_load, q_in, u_C,
    output req_ready, q_ack, u_valid, u_op, u_A, u_B, u_q, rsp_valid, rsp_C, busy
  );

  // Environment side: lane controllers plus the shared modop unit.
  modport master (
    output req_valid, req_op, req_A, req_B, q_load, q_in, u_C,
    input  req_ready, q_ack, u_valid, u_op, u_A, u_B, u_q, rsp_valid, rsp_C, busy
  );
endinterface

// File: rtl/modop_arbiter.sv
// modop_arbiter: shares one pipelined modular add/sub unit (latency LAT >= 2)
// among NREQ requesters. One grant per cycle, results routed back by tag, and
// modulus updates serialised behind in-flight operations.
// Build option: MODOP_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, no rotation pointer); default is round-robin.
module modop_arbiter #(
  parameter int NREQ = 4,
  parameter int LOGQ = 64,
  parameter int LAT  = 3
) (
  input logic            clk,
  input logic            rst,
  modop_arbiter_if.slave bus
);
  localparam int TAGW = $clog2(NREQ);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_issue_en;
  logic            w_q_ack;
  logic            w_drained;
  logic            w_hit;
  logic            w_any_gnt;
  logic [TAGW-1:0] w_gnt_id;
  logic [NREQ-1:0] w_grant;
  logic [LAT-1:0]  r_tag_vld;
  logic [TAGW-1:0] r_tag_id [LAT];
  logic [NREQ-1:0] r_rsp_valid;
  logic [LOGQ-1:0] r_rsp_c;
  logic [LOGQ-1:0] r_q;
`ifndef MODOP_ARB_FIXED_PRIO_EN
  logic [TAGW-1:0] r_ptr;
  logic [TAGW:0]   w_idx;
`endif

  // Modulus-update sequencer state register.
  // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  // Nothing in the tag pipe and nothing sitting in the response register.
  assign w_drained = ~|r_tag_vld && ~|r_rsp_valid;

  // Next state: a load request stops issue; when already drained DRAIN is skipped.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:   if (bus.q_load) w_state_nxt = w_drained ? ST_LOAD : ST_DRAIN;
      ST_DRAIN: if (w_drained)  w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // Sequencer outputs: issue only in RUN with no load pending; ack while loading.
  always_comb begin
    w_issue_en = (r_state == ST_RUN) && !bus.q_load;
    w_q_ack    = (r_state == ST_LOAD);
  end

  // Grant selection: first valid requester from the pointer (or from index 0).
  always_comb begin
    w_hit    = 1'b0;
    w_gnt_id = '0;
`ifdef MODOP_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_hit    = 1'b1;
        w_gnt_id = TAGW'(i);
      end
    end
`else
    w_idx = '0;
    // Scan backwards so the last hit written is the closest to the pointer.
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (TAGW + 1)'(k);
      if (w_idx >= (TAGW + 1)'(NREQ)) w_idx = w_idx - (TAGW + 1)'(NREQ);
      if (bus.req_valid[w_idx[TAGW-1:0]]) begin
        w_hit    = 1'b1;
        w_gnt_id = w_idx[TAGW-1:0];
      end
    end
`endif
    w_any_gnt = w_hit && w_issue_en;
    w_grant   = w_any_gnt ? (NREQ'(1) << w_gnt_id) : '0;
  end

`ifndef MODOP_ARB_FIXED_PRIO_EN
  // Rotate the pointer past the requester just served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_ptr <= '0;
    else if (w_any_gnt) r_ptr <= (w_gnt_id == TAGW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
  end
`endif

  // Operand mux towards the unit; zero when nothing is issued.
  always_comb begin
    bus.u_A  = '0;
    bus.u_B  = '0;
    bus.u_op = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        bus.u_A  = bus.req_A[i*LOGQ +: LOGQ];
        bus.u_B  = bus.req_B[i*LOGQ +: LOGQ];
        bus.u_op = bus.req_op[i];
      end
    end
  end

  // Tag-valid shift register; the head slot lines up with u_C.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tag_vld <= '0;
    else      r_tag_vld <= {r_tag_vld[LAT-2:0], w_any_gnt};
  end

  // Requester-id shift register alongside the valids.
  // NOTE: ids carry no reset; r_tag_vld alone decides whether a slot means anything.
  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_gnt_id;
    for (int i = 1; i < LAT; i++) r_tag_id[i] <= r_tag_id[i-1];
  end

  // Register the unit result and strobe the originating requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid <= '0;
      r_rsp_c     <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (r_tag_vld[LAT-1]) begin
        r_rsp_valid <= NREQ'(1) << r_tag_id[LAT-1];
        r_rsp_c     <= bus.u_C;
      end
    end
  end

  // Modulus register, written only once the pipe has drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_q <= '0;
    else if (r_state == ST_LOAD) r_q <= bus.q_in;
  end

  assign bus.req_ready = w_grant;
  assign bus.u_valid   = w_any_gnt;
  assign bus.u_q       = r_q;
  assign bus.q_ack     = w_q_ack;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_C     = r_rsp_c;
  assign bus.busy      = |r_tag_vld;

endmodule

// File: tb/tb_modop_arbiter.sv
// tb_modop_arbiter: directed test-plan scenarios plus a randomized phase, all
// checked cycle by cycle against a transaction-level reference model (grant
// order, expected-response queue, modulus-load timing rule).
module tb_modop_arbiter;
  localparam int NREQ = 4;
  localparam int LOGQ = 64;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  modop_arbiter_if #(.NREQ(NREQ), .LOGQ(LOGQ)) bus ();

  modop_arbiter #(.NREQ(NREQ), .LOGQ(LOGQ), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- shared modop unit model (environment) ----------------
  function automatic logic [LOGQ-1:0] unit_calc(input logic op, input logic [LOGQ-1:0] a,
                                                input logic [LOGQ-1:0] b, input logic [LOGQ-1:0] q);
    logic [LOGQ:0] s;
    if (!op) begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, q}) s = s - {1'b0, q};
      return s[LOGQ-1:0];
    end
    return (a >= b) ? (a - b) : (a - b + q);
  endfunction

  logic [LOGQ-1:0] unit_pipe [LAT];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) unit_pipe[i] <= '0;
    end else begin
      unit_pipe[0] <= unit_calc(bus.u_op, bus.u_A, bus.u_B, bus.u_q);
      for (int i = 1; i < LAT; i++) unit_pipe[i] <= unit_pipe[i-1];
    end
  end
  assign bus.u_C = unit_pipe[LAT-1];

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned     due;
    int              id;
    logic [LOGQ-1:0] val;
  } exp_t;

  exp_t            exp_q[$];
  int unsigned     cyc, last_due, ack_cyc;
  int              m_ptr;
  bit              load_pend, acked_now;
  logic [LOGQ-1:0] m_q, m_rsp_c;

  // Modular result straight from the definition: (a +/- b) mod q.
  function automatic logic [LOGQ-1:0] ref_modop(input logic op, input logic [LOGQ-1:0] a,
                                                input logic [LOGQ-1:0] b, input logic [LOGQ-1:0] q);
    logic [LOGQ+1:0] t;
    t = op ? ({2'b0, a} + {2'b0, q} - {2'b0, b}) : ({2'b0, a} + {2'b0, b});
    t = t % {2'b0, q};
    return t[LOGQ-1:0];
  endfunction

  // ---------------- stimulus state ----------------
  logic [NREQ-1:0] s_valid, s_op;
  logic [LOGQ-1:0] s_A [NREQ];
  logic [LOGQ-1:0] s_B [NREQ];
  logic            s_load;
  logic [LOGQ-1:0] s_qin;
  logic [NREQ-1:0] obs_ready;
  logic            obs_ack;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [LOGQ-1:0] got, input logic [LOGQ-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [LOGQ-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [LOGQ-1:0] rnd_below(input logic [LOGQ-1:0] q);
    if (q == '0) return '0;
    return rnd64() % q;
  endfunction

  task automatic drive();
    bus.req_valid = s_valid;
    bus.req_op    = s_op;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_A[i*LOGQ +: LOGQ] = s_A[i];
      bus.req_B[i*LOGQ +: LOGQ] = s_B[i];
    end
    bus.q_load = s_load;
    bus.q_in   = s_qin;
  endtask

  task automatic rand_ops(input int pct_valid);
    for (int i = 0; i < NREQ; i++) begin
      s_valid[i] = ($urandom_range(0, 99) < pct_valid);
      s_op[i]    = 1'($urandom_range(0, 1));
      s_A[i]     = rnd_below(m_q);
      s_B[i]     = rnd_below(m_q);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_due  = 0;
    ack_cyc   = 0;
    m_ptr     = 0;
    load_pend = 1'b0;
    acked_now = 1'b0;
    m_q       = '0;
    m_rsp_c   = '0;
  endtask

  // One clock cycle: drive, check every output against the model, advance the model.
  task automatic run_cycle();
    int              g, idx;
    logic [NREQ-1:0] e_ready, e_rsp;
    bit              e_busy;
    @(posedge clk);
    #1;
    cyc++;
    acked_now = 1'b0;
    drive();
    @(negedge clk);
    obs_ready = bus.req_ready;
    obs_ack   = bus.q_ack;

    // Modulus load: ack once issue has stopped and the last result has left.
    if (s_load && !load_pend) begin
      load_pend = 1'b1;
      ack_cyc   = (cyc + 1 > last_due + 2) ? cyc + 1 : last_due + 2;
    end

    g = -1;
    if (!load_pend) begin
      for (int k = 0; k < NREQ; k++) begin
`ifdef MODOP_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (m_ptr + k) % NREQ;
`endif
        if (g < 0 && s_valid[idx]) g = idx;
      end
    end
    e_ready = (g >= 0) ? (NREQ'(1) << g) : '0;

    check("req_ready", LOGQ'(bus.req_ready), LOGQ'(e_ready));
    check("u_valid", LOGQ'(bus.u_valid), LOGQ'(g >= 0));
    if (g >= 0) begin
      check("u_op", LOGQ'(bus.u_op), LOGQ'(s_op[g]));
      check("u_A", bus.u_A, s_A[g]);
      check("u_B", bus.u_B, s_B[g]);
    end else begin
      check("u_op_idle", LOGQ'(bus.u_op), '0);
      check("u_A_idle", bus.u_A, '0);
      check("u_B_idle", bus.u_B, '0);
    end
    check("u_q", bus.u_q, m_q);
    check("q_ack", LOGQ'(bus.q_ack), LOGQ'(load_pend && cyc == ack_cyc));

    e_rsp = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e_rsp   = NREQ'(1) << exp_q[0].id;
      m_rsp_c = exp_q[0].val;
      void'(exp_q.pop_front());
    end
    check("rsp_valid", LOGQ'(bus.rsp_valid), LOGQ'(e_rsp));
    check("rsp_C", bus.rsp_C, m_rsp_c);

    e_busy = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].due - LAT <= cyc) e_busy = 1'b1;
    check("busy", LOGQ'(bus.busy), LOGQ'(e_busy));

    if (g >= 0) begin
      exp_q.push_back('{due: cyc + LAT + 1, id: g, val: ref_modop(s_op[g], s_A[g], s_B[g], m_q)});
      last_due = cyc + LAT + 1;
      m_ptr    = (g + 1) % NREQ;
    end
    if (load_pend && cyc == ack_cyc) begin
      m_q       = s_qin;
      load_pend = 1'b0;
      acked_now = 1'b1;
    end
  endtask

  // Hold q_load until the DUT acks (bounded); returns cycles from request to ack.
  task automatic do_load(input logic [LOGQ-1:0] qin, output int ack_after);
    int n;
    s_load = 1'b1;
    s_qin  = qin;
    n      = 0;
    do begin
      run_cycle();
      n++;
    end while (!obs_ack && n < 20);
    check("q_ack_seen", LOGQ'(obs_ack), 1);
    s_load    = 1'b0;
    ack_after = n - 1;
  endtask

  task automatic idle(input int n);
    s_valid = '0;
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ack_after;
    s_valid = '0;
    s_op    = '0;
    s_load  = 1'b0;
    s_qin   = '0;
    for (int i = 0; i < NREQ; i++) begin
      s_A[i] = '0;
      s_B[i] = '0;
    end
    cyc = 0;
    model_reset();

    // Reset state; arbitration stays combinational during reset.
    s_valid = 4'b0100;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", LOGQ'(bus.rsp_valid), '0);
    check("rst_rsp_C", bus.rsp_C, '0);
    check("rst_busy", LOGQ'(bus.busy), '0);
    check("rst_q_ack", LOGQ'(bus.q_ack), '0);
    check("rst_u_q", bus.u_q, '0);
    check("rst_req_ready", LOGQ'(bus.req_ready), LOGQ'(4'b0100));
    s_valid = '0;
    drive();
    @(posedge clk);
    #1 rst = 1'b1;

    // Empty-pipe modulus load: ack one cycle after the request.
    do_load(LOGQ'(64'h11), ack_after);
    check("load_empty_latency", LOGQ'(ack_after), 1);
    idle(1);

    // Fairness: all four requesters valid for eight cycles.
    for (int n = 0; n < 8; n++) begin
      rand_ops(100);
      s_valid = '1;
      run_cycle();
`ifdef MODOP_ARB_FIXED_PRIO_EN
      check("fair_order", LOGQ'(obs_ready), LOGQ'(4'b0001));
`else
      check("fair_order", LOGQ'(obs_ready), LOGQ'(NREQ'(1) << (n % NREQ)));
`endif
    end
    idle(5);

    // Single op: requester 2, sub 5 - 9 mod 0x11.
    s_valid = 4'b0100;
    s_op[2] = 1'b1;
    s_A[2]  = 64'd5;
    s_B[2]  = 64'd9;
    run_cycle();
    check("single_grant", LOGQ'(obs_ready), LOGQ'(4'b0100));
    s_valid = '0;
    for (int n = 0; n < LAT; n++) begin
      run_cycle();
      check("single_busy", LOGQ'(bus.busy), 1);
    end
    run_cycle();
    check("single_rsp_valid", LOGQ'(bus.rsp_valid), LOGQ'(4'b0100));
    check("single_rsp_C", bus.rsp_C, LOGQ'(64'h0D));
    idle(2);

    // Simultaneous q_load and request: load wins, request served after the ack.
    s_valid = 4'b0001;
    s_op[0] = 1'b0;
    s_A[0]  = 64'd3;
    s_B[0]  = 64'd4;
    s_load  = 1'b1;
    s_qin   = 64'h11;
    run_cycle();
    check("simul_ready_blocked", LOGQ'(obs_ready), '0);
    run_cycle();
    check("simul_ack", LOGQ'(obs_ack), 1);
    check("simul_ready_ack", LOGQ'(obs_ready), '0);
    s_load = 1'b0;
    run_cycle();
    check("simul_grant_after", LOGQ'(obs_ready), LOGQ'(4'b0001));
    idle(6);

    // Modulus swap with a full pipe; requesters stay valid through the drain.
    for (int n = 0; n < LAT; n++) begin
      rand_ops(100);
      s_valid = '1;
      run_cycle();
    end
    do_load(LOGQ'(64'h1D), ack_after);
    check("load_full_latency", LOGQ'(ack_after), LOGQ'(LAT + 2));
    s_valid = 4'b0001;
    s_op[0] = 1'b0;
    s_A[0]  = 64'h1C;
    s_B[0]  = 64'h02;
    run_cycle();
    check("swap_no_ack", LOGQ'(obs_ack), '0);
    check("swap_grant", LOGQ'(obs_ready), LOGQ'(4'b0001));
    s_valid = '0;
    for (int n = 0; n < LAT + 1; n++) run_cycle();
    check("swap_rsp_valid", LOGQ'(bus.rsp_valid), LOGQ'(4'b0001));
    check("swap_rsp_C", bus.rsp_C, LOGQ'(64'h01));
    idle(2);

    // Two requesters continuously valid.
    for (int n = 0; n < 6; n++) begin
      rand_ops(100);
      s_valid = 4'b1010;
      run_cycle();
`ifdef MODOP_ARB_FIXED_PRIO_EN
      check("fixed_prio_grant", LOGQ'(obs_ready), LOGQ'(4'b0010));
`endif
    end
    idle(5);

    // Randomized traffic with occasional modulus updates.
    for (int n = 0; n < 1500; n++) begin
      rand_ops(60);
      if (!s_load && $urandom_range(0, 39) == 0) begin
        s_load = 1'b1;
        s_qin  = ($urandom_range(0, 1) == 1) ? rnd64() : LOGQ'($urandom_range(2, 1000));
        if (s_qin < 2) s_qin = 2;
      end
      run_cycle();
      if (acked_now) s_load = 1'b0;
    end
    s_valid = '0;
    for (int n = 0; n < 20 && s_load; n++) begin
      run_cycle();
      if (acked_now) s_load = 1'b0;
    end
    idle(6);

    // Reset mid-flight: four ops issued, first result visible, three in flight.
    for (int n = 0; n < 4; n++) begin
      rand_ops(100);
      s_valid = 4'b0001;
      run_cycle();
    end
    @(posedge clk);
    #1;
    s_valid = '0;
    drive();
    check("pre_rst_rsp_valid", LOGQ'(bus.rsp_valid), LOGQ'(4'b0001));
    #2 rst = 1'b0;
    #1;
    check("midrst_rsp_valid", LOGQ'(bus.rsp_valid), '0);
    check("midrst_busy", LOGQ'(bus.busy), '0);
    check("midrst_u_q", bus.u_q, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("post_rst_u_q", bus.u_q, '0);
    check("post_rst_rsp_C", bus.rsp_C, '0);
    idle(6);
    do_load(LOGQ'(64'h11), ack_after);
    rand_ops(100);
    s_valid = '1;
    run_cycle();
    check("post_rst_ptr", LOGQ'(obs_ready), LOGQ'(4'b0001));
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/modop_arbiter.md
# modop_arbiter

Round-robin scheduler that shares one pipelined modular add/sub unit (fixed latency LAT) among NREQ requesters. Per-requester valid/ready handshakes are accepted, one operation is issued per cycle, each issue is tracked with a requester tag, and every result is routed back to its originator. It also owns the modulus register `q` and serialises modulus updates against in-flight operations. It sits between the NTT/poly-arithmetic lane controllers and the shared modop datapath.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `LOGQ`, 64: operand, modulus and result width.
- `LAT`, 3: unit latency in cycles, from `u_valid` to `u_C`. Equals FF_IN+FF_ADD+FF_OUT.
- `TAGW`, $clog2(NREQ): requester-id width.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester operation valid.
- `req_ready`  out  NREQ  per-requester accept (one-hot or zero).
- `req_op`  in  NREQ  per-requester op: 0 = add, 1 = sub.
- `req_A`, `req_B`  in  NREQ*LOGQ  packed operands. Requester i occupies bits [i*LOGQ +: LOGQ].
- `q_load`  in  1  request modulus update (level, held until `q_ack`).
- `q_in`  in  LOGQ  new modulus.
- `q_ack`  out  1  one-cycle pulse when `q` is updated.
- `u_valid`, `u_op`  out  1  issue strobe and op to unit.
- `u_A`, `u_B`, `u_q`  out  LOGQ  unit operands; `u_q` = modulus register.
- `u_C`  in  LOGQ  unit result, valid LAT cycles after issue.
- `rsp_valid`  out  NREQ  one-hot result strobe.
- `rsp_C`  out  LOGQ  result data.
- `busy`  out  1  any operation in flight.

## Operation
- **Arbitration** (combinational): round-robin starting at pointer `ptr`.
  - The first i, taken cyclically from `ptr`, with `req_valid[i]=1` gets `req_ready[i]=1`. The handshake completes in the same cycle.
  - On a grant to i, `ptr` <= (i+1) mod NREQ. With no grant, `ptr` holds.
- **Issue**: `u_valid` = |grant. `u_A`, `u_B`, `u_op` are muxed combinationally from the granted requester. They are don't-care (drive 0) when `u_valid`=0.
- **Tag pipe**: a LAT-deep shift register of {valid, id}, advancing every cycle. The unit never stalls; results carry no backpressure.
- **Response**: when the tag pipe head is valid:
  - `rsp_C` <= `u_C` (registered).
  - `rsp_valid` <= onehot(id).
  - Otherwise `rsp_valid` <= 0 and `rsp_C` holds.
- **Modulus update states**: RUN → DRAIN → LOAD → RUN.
  - RUN → DRAIN: on `q_load=1`. From this point no grants are made (`req_ready`=0).
  - DRAIN → LOAD: once the tag pipe is empty and no result remains pending in the response register.
  - LOAD: `q` <= `q_in`, `q_ack`=1 for one cycle, then back to RUN.
  - `q_load` arriving in the same cycle as a request: the load wins and that request is not granted.
- **`busy`**: 1 while any tag-pipe entry is valid.
- **Reset (async, `rst`=0)**:
  - Cleared to 0: `ptr`, tag pipe, `rsp_valid`, `rsp_C`, `q`, `q_ack`.
  - State = RUN.
  - Combinational outputs follow: `req_ready`=0 only if no valid requests.
  - Reset mid-operation discards in-flight results; no `rsp_valid` is produced for them.
- Arithmetic is performed entirely by the unit. This block never modifies operand bits.

## Timing
- Accept in cycle T → `rsp_valid` in cycle T+LAT+1.
- Throughput: one operation per cycle aggregate. A single continuously-valid requester among N active ones is served once every N cycles.
- Modulus update:
  - Empty pipe: `q_load` at T → `q_ack` at T+1, new `q` visible on `u_q` from T+2.
  - Full pipe: `q_ack` no later than T+LAT+2.
- `req_ready` is combinational from `req_valid`, `ptr` and state. There is no path from `req_ready` to `req_valid` inside this block.

## Configuration
- `MODOP_ARB_FIXED_PRIO_EN`:
  - **Defined**: fixed priority, lowest index wins; `ptr` is removed.
  - **Undefined (default)**: round-robin as above.
  - All other behaviour is identical in both builds.

## Test plan
- **Single op.** Setup: NREQ=4, LAT=3, q=0x11; requester 2 sends sub A=5, B=9 at cycle T. Required: `rsp_valid`=4'b0100 with `rsp_C`=0x0D at T+4; `busy` high T+1..T+3.
- **Fairness.** All four requesters hold valid for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; each `rsp_valid` matches the granting requester's id 4 cycles later.
- **Modulus swap.** Pipe full; `q_load` with q_in=0x1D. Required: no grants during drain; `q_ack` once; the next add A=0x1C, B=0x02 gives 0x01.
- **Simultaneous load and request.** `q_load` and `req_valid[0]` rise in the same cycle. Required: `req_ready`=0 that cycle; the request is granted the cycle after `q_ack`.
- **Reset mid-flight.** `rst`=0 asynchronously with 3 operations in flight. Required: `rsp_valid`=0 immediately and no later responses; `q`=0 and `ptr`=0 after release.
- **Fixed-priority build** (`MODOP_ARB_FIXED_PRIO_EN` defined), requesters 1 and 3 continuously valid. Required: requester 1 is granted every cycle and requester 3 never.
